// File: rtl/adder_pipe.sv
// adder_pipe: pipelined two's-complement adder/subtractor with valid/ready
// handshake on both sides and carry/overflow/zero flags.
// The WIDTH-bit add is cut into STAGES segments of CH = ceil(WIDTH/STAGES)
// bits. Each stage adds its own segment and registers the carry out for the
// next stage. Stages whose segment lies past the MSB only pass the beat on,
// so the latency is always STAGES cycles.
// Optional build macro ADDER_PIPE_SAT_EN adds a per-beat `sat` input. When
// sat is set and the add overflows, q clamps to signed max or signed min.
module adder_pipe #(
  parameter int WIDTH  = 15,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef ADDER_PIPE_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CH = (WIDTH + STAGES - 1) / STAGES;
  // Number of intermediate stage registers. It is never zero, so the arrays
  // below stay legal when STAGES == 1.
  localparam int NI = (STAGES > 1) ? STAGES - 1 : 1;

  typedef struct packed {
    logic             ovf;
    logic             carry;
    logic [WIDTH-1:0] res;
  } seg_t;

  // Ripple-add the bits of segment k and leave all other result bits as they
  // are. The signed overflow flag is produced by whichever segment holds the
  // MSB. A segment that lies past the MSB passes the carry and ovf through.
  function automatic seg_t seg_add(input int k,
                                   input logic [WIDTH-1:0] av,
                                   input logic [WIDTH-1:0] bv,
                                   input logic [WIDTH-1:0] rin,
                                   input logic cin_v,
                                   input logic ovf_in);
    seg_t r;
    logic c;
    logic co;
    r.res = rin;
    r.ovf = ovf_in;
    c     = cin_v;
    co    = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= k * CH && i < (k + 1) * CH) begin
        co       = (av[i] & bv[i]) | (av[i] & c) | (bv[i] & c);
        r.res[i] = av[i] ^ bv[i] ^ c;
        if (i == WIDTH - 1) r.ovf = c ^ co;
        c = co;
      end
    end
    r.carry = c;
    return r;
  endfunction

  logic [STAGES-1:0] v;
  logic [STAGES:0]   rdy;
  logic              sat_in;

  logic [WIDTH-1:0] r_a   [NI];
  logic [WIDTH-1:0] r_b   [NI];
  logic [WIDTH-1:0] r_res [NI];
  logic             r_c   [NI];
  logic             r_o   [NI];
  logic             r_s   [NI];

`ifdef ADDER_PIPE_SAT_EN
  assign sat_in = sat;
`else
  assign sat_in = 1'b0;
`endif

  // Ready ripples back from the output. A stage can take a new beat when it
  // is empty or when its current beat moves on at the same edge.
  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];
  assign out_valid   = v[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             in_v;
    logic             in_c;
    logic             in_o;
    logic             in_s;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_r;
    logic             vr;
    seg_t             nx;

    assign rdy[k] = ~vr | rdy[k+1];
    assign v[k]   = vr;

    if (k == 0) begin : g_src_in
      // B is inverted once here. Later stages only see B'.
      assign in_v = in_valid;
      assign in_a = a;
      assign in_b = sub ? ~b : b;
      assign in_c = sub ? 1'b1 : cin;
      assign in_r = '0;
      assign in_o = 1'b0;
      assign in_s = sat_in;
    end else begin : g_src_prev
      assign in_v = v[k-1];
      assign in_a = r_a[k-1];
      assign in_b = r_b[k-1];
      assign in_c = r_c[k-1];
      assign in_r = r_res[k-1];
      assign in_o = r_o[k-1];
      assign in_s = r_s[k-1];
    end

    assign nx = seg_add(k, in_a, in_b, in_r, in_c, in_o);

    // Valid bit of this stage; it loads whenever the stage is allowed to take a beat
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vr <= 1'b0;
      else if (rdy[k]) vr <= in_v;
    end

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] ra_q;
      logic [WIDTH-1:0] rb_q;
      logic [WIDTH-1:0] rr_q;
      logic             rc_q;
      logic             ro_q;
      logic             rs_q;

      // Capture the partial sum, segment carry and remaining operands of an accepted beat
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ra_q <= '0;
          rb_q <= '0;
          rr_q <= '0;
          rc_q <= 1'b0;
          ro_q <= 1'b0;
          rs_q <= 1'b0;
        end else if (rdy[k] && in_v) begin
          ra_q <= in_a;
          rb_q <= in_b;
          rr_q <= nx.res;
          rc_q <= nx.carry;
          ro_q <= nx.ovf;
          rs_q <= in_s;
        end
      end

      assign r_a[k]   = ra_q;
      assign r_b[k]   = rb_q;
      assign r_res[k] = rr_q;
      assign r_c[k]   = rc_q;
      assign r_o[k]   = ro_q;
      assign r_s[k]   = rs_q;
    end else begin : g_out
      logic [WIDTH-1:0] fq;
      logic [WIDTH-1:0] q_q;
      logic             c_q;
      logic             o_q;
      logic             z_q;

      // Clamp on overflow when saturation is requested. A set MSB after an
      // overflow means the true result was positive.
      always_comb begin
        fq = nx.res;
        if (in_s && nx.ovf) begin
          fq = nx.res[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                               : {1'b1, {(WIDTH-1){1'b0}}};
        end
      end

      // Output register; it holds while the stage is full and downstream stalls
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_q <= '0;
          c_q <= 1'b0;
          o_q <= 1'b0;
          z_q <= 1'b0;
        end else if (rdy[k] && in_v) begin
          q_q <= fq;
          c_q <= nx.carry;
          o_q <= nx.ovf;
          z_q <= ~|fq;
        end
      end

      assign q    = q_q;
      assign cout = c_q;
      assign ovf  = o_q;
      assign zero = z_q;
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe at WIDTH=15, STAGES=3. Expected values are
// worked out by hand. Inputs change on the falling edge and outputs are
// sampled 1 ns later.
module tb_adder_pipe;
  localparam int W = 15;
  localparam int S = 3;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         cin       = 1'b0;
  logic         sub       = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] q;
  logic         cout;
  logic         ovf;
  logic         zero;
`ifdef ADDER_PIPE_SAT_EN
  logic         sat       = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
`ifdef ADDER_PIPE_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated beat; checks exact 3-cycle latency, then the result flags
  task automatic run_one(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic c, input logic s,
                         input logic [W-1:0] eq, input logic ec,
                         input logic eo, input logic ez);
    @(negedge clk);
    a = av; b = bv; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    #1 check("one_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("one_lat_e1", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 check("one_lat_e2", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    check("one_valid", 32'(out_valid), 32'd1);
    check("one_q",     32'(q),    32'(eq));
    check("one_cout",  32'(cout), 32'(ec));
    check("one_ovf",   32'(ovf),  32'(eo));
    check("one_zero",  32'(zero), 32'(ez));
  endtask

  // Beats i = 0..n-1 with a=b=i, cin=1, so the expected q is 2i+1. out_ready is low for cycles [st0, st0+stlen).
  task automatic run_stream(input int n, input int st0, input int stlen);
    int idx = 0;
    int got = 0;
    int first = -1;
    int last = -1;
    int cyc = 0;
    logic held = 1'b0;
    logic [W-1:0] hq = '0;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      in_valid  = (idx < n);
      a         = idx[W-1:0];
      b         = idx[W-1:0];
      cin       = 1'b1;
      sub       = 1'b0;
      out_ready = !(cyc >= st0 && cyc < st0 + stlen);
      #1;
      if (stlen == 0 && idx < n) check("strm_in_ready", 32'(in_ready), 32'd1);
      if (held) check("stall_hold_q", 32'(q), 32'(hq));
      if (stlen > 0 && cyc == st0 + stlen - 1) begin
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_in_flight", 32'(idx - got), 32'(S));
      end
      if (out_valid && out_ready) begin
        check("strm_q", 32'(q), 32'((2 * got + 1) & 32'h7FFF));
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      held = out_valid && !out_ready;
      hq   = q;
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("strm_count", 32'(got), 32'(n));
    if (stlen == 0) check("strm_rate", 32'(last - first), 32'(n - 1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 check("strm_no_dup", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_q",         32'(q),         32'd0);
    check("rst_flags",     {29'd0, cout, ovf, zero}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //      a         b        cin   sub    q         cout  ovf   zero
    run_one(15'h7FFF, 15'h0001, 1'b0, 1'b0, 15'h0000, 1'b1, 1'b0, 1'b1);
    run_one(15'h3FFF, 15'h0001, 1'b0, 1'b0, 15'h4000, 1'b0, 1'b1, 1'b0);
    run_one(15'h0005, 15'h0007, 1'b0, 1'b1, 15'h7FFE, 1'b0, 1'b0, 1'b0);
    run_one(15'h0007, 15'h0005, 1'b0, 1'b1, 15'h0002, 1'b1, 1'b0, 1'b0);
    run_one(15'h0007, 15'h0005, 1'b1, 1'b1, 15'h0002, 1'b1, 1'b0, 1'b0);
    run_one(15'h001F, 15'h0001, 1'b0, 1'b0, 15'h0020, 1'b0, 1'b0, 1'b0);
    run_one(15'h03FF, 15'h0000, 1'b1, 1'b0, 15'h0400, 1'b0, 1'b0, 1'b0);
    run_one(15'h4000, 15'h4000, 1'b0, 1'b0, 15'h0000, 1'b1, 1'b1, 1'b1);
    run_one(15'h4000, 15'h0001, 1'b0, 1'b1, 15'h3FFF, 1'b1, 1'b1, 1'b0);
`ifdef ADDER_PIPE_SAT_EN
    sat = 1'b1;
    run_one(15'h3FFF, 15'h0001, 1'b0, 1'b0, 15'h3FFF, 1'b0, 1'b1, 1'b0);
    run_one(15'h4000, 15'h0001, 1'b0, 1'b1, 15'h4000, 1'b1, 1'b1, 1'b0);
    run_one(15'h0007, 15'h0005, 1'b0, 1'b1, 15'h0002, 1'b1, 1'b0, 1'b0);
    sat = 1'b0;
`endif

    run_stream(10, 0, 0);
    run_stream(10, 2, 6);

    // Fill the pipe with out_ready low, then reset while beats are in flight
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; cin = 1'b0; sub = 1'b0;
    a = 15'd3; b = 15'd4;
    @(negedge clk);
    a = 15'd10; b = 15'd1;
    @(negedge clk);
    a = 15'd20; b = 15'd2;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_q",     32'(q),         32'd7);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_q",         32'(q),         32'd0);
    check("mid_rst_flags",     {29'd0, cout, ovf, zero}, 32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    run_one(15'h0001, 15'h0001, 1'b0, 1'b0, 15'h0002, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1 check("post_rst_no_stale", 32'(out_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
